// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 register file (BadVAddr, Count, Compare, Status, Cause, EPC).
// Sits after write-back: takes exception/eret/mtc0 commits and serves mfc0 reads.
// Optional feature macro: CP0_TIMER_EN builds Count/Compare and the timer interrupt (TI).
module cp0_regfile #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_ex,
  input  logic [4:0]  ws_excode,
  input  logic [31:0] ws_badvaddr,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic        eret_flush,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic [5:0]  ext_int,
  output logic [31:0] cp0_rdata,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic        has_int
);

  localparam logic [4:0] AddrBadVAddr = 5'd8;
  localparam logic [4:0] AddrCount    = 5'd9;
  localparam logic [4:0] AddrCompare  = 5'd11;
  localparam logic [4:0] AddrStatus   = 5'd12;
  localparam logic [4:0] AddrCause    = 5'd13;
  localparam logic [4:0] AddrEpc      = 5'd14;
  localparam logic [4:0] ExcAdel      = 5'h04;
  localparam logic [4:0] ExcAdes      = 5'h05;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic [4:0]  exccode_q, exccode_d;
  logic        ti;
  logic [31:0] count_rd, compare_rd;
  logic [7:0]  ip;
  logic        mtc0_en;

  // mtc0 only takes effect when no exception or eret commits in the same cycle
  assign mtc0_en = mtc0_we & ~ws_ex & ~eret_flush;

  // Next state for Status/Cause/EPC/BadVAddr: exception > eret > mtc0
  always_comb begin
    badvaddr_d = badvaddr_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    if (ws_ex) begin
      exl_d     = 1'b1;
      exccode_d = ws_excode;
      // Nested exceptions keep the original return point
      if (!exl_q) begin
        epc_d = ws_bd ? ws_pc - 32'd4 : ws_pc;
        bd_d  = ws_bd;
      end
      if (ws_excode == ExcAdel || ws_excode == ExcAdes) begin
        badvaddr_d = ws_badvaddr;
      end
    end else if (eret_flush) begin
      exl_d = 1'b0;
    end else if (mtc0_en) begin
      // BadVAddr is hardware-written only
      case (cp0_addr)
        AddrStatus: begin
          im_d  = cp0_wdata[15:8];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        AddrCause: ip_sw_d = cp0_wdata[9:8];
        AddrEpc:   epc_d   = cp0_wdata;
        default: ;
      endcase
    end
  end

  // Architectural state registers, plus the external interrupt sampler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr_q <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exccode_q  <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ext_int;
      exccode_q  <= exccode_d;
    end
  end

`ifdef CP0_TIMER_EN
  localparam logic [3:0] TickLast = 4'(COUNT_DIV - 1);

  logic [3:0]  tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        count_chg_q, cmp_wr_q;
  logic        count_wr, cmp_wr;

  assign count_wr = mtc0_en && (cp0_addr == AddrCount);
  assign cmp_wr   = mtc0_en && (cp0_addr == AddrCompare);

  // Count prescaler, Compare load and TI set/clear
  always_comb begin
    tick_d    = tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_wr) begin
      count_d = cp0_wdata;
      tick_d  = '0;
    end else if (tick_q == TickLast) begin
      tick_d  = '0;
      count_d = count_q + 32'd1;
    end else begin
      tick_d = tick_q + 4'd1;
    end
    // A Compare write clears TI and beats a match in the same cycle; a match right after a
    // Compare write only counts if Count moved too.
    if (cmp_wr) begin
      compare_d = cp0_wdata;
      ti_d      = 1'b0;
    end else if ((count_q == compare_q) && (count_chg_q || !cmp_wr_q)) begin
      ti_d = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q      <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      ti_q        <= 1'b0;
      count_chg_q <= 1'b0;
      cmp_wr_q    <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      ti_q        <= ti_d;
      count_chg_q <= (count_d != count_q);
      cmp_wr_q    <= cmp_wr;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  assign ip         = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
  assign cp0_status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cp0_cause  = {bd_q, ti, 14'd0, ip, 1'b0, exccode_q, 2'b00};
  assign cp0_epc    = epc_q;
  assign has_int    = (|(ip & im_q)) & ie_q & ~exl_q;

  // mfc0 read mux; reflects registered state only
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      AddrBadVAddr: cp0_rdata = badvaddr_q;
      AddrCount:    cp0_rdata = count_rd;
      AddrCompare:  cp0_rdata = compare_rd;
      AddrStatus:   cp0_rdata = cp0_status;
      AddrCause:    cp0_rdata = cp0_cause;
      AddrEpc:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: stimulus queues expectations, a negedge monitor checks them.
module tb_cp0_regfile;

`ifdef CP0_TIMER_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ws_ex = 1'b0;
  logic [4:0]  ws_excode = '0;
  logic [31:0] ws_badvaddr = '0;
  logic        ws_bd = 1'b0;
  logic [31:0] ws_pc = '0;
  logic        eret_flush = 1'b0;
  logic        mtc0_we = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] cp0_wdata = '0;
  logic [5:0]  ext_int = '0;
  logic [31:0] cp0_rdata, cp0_epc, cp0_status, cp0_cause;
  logic        has_int;

  cp0_regfile #(.COUNT_DIV(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ws_ex      (ws_ex),
    .ws_excode  (ws_excode),
    .ws_badvaddr(ws_badvaddr),
    .ws_bd      (ws_bd),
    .ws_pc      (ws_pc),
    .eret_flush (eret_flush),
    .mtc0_we    (mtc0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .ext_int    (ext_int),
    .cp0_rdata  (cp0_rdata),
    .cp0_epc    (cp0_epc),
    .cp0_status (cp0_status),
    .cp0_cause  (cp0_cause),
    .has_int    (has_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  addr;
    bit          chk_rd;
    logic [31:0] rd;
    logic        hint;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Monitor: one expectation consumed per falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk_rd) begin
        n_chk++;
        if (cp0_rdata === e.rd) n_pass++;
        else $display("FAIL %s rdata: got %h expected %h", e.name, cp0_rdata, e.rd);
        if (e.addr == 5'd12) begin
          n_chk++;
          if (cp0_status === e.rd) n_pass++;
          else $display("FAIL %s cp0_status: got %h expected %h", e.name, cp0_status, e.rd);
        end
        if (e.addr == 5'd13) begin
          n_chk++;
          if (cp0_cause === e.rd) n_pass++;
          else $display("FAIL %s cp0_cause: got %h expected %h", e.name, cp0_cause, e.rd);
        end
        if (e.addr == 5'd14) begin
          n_chk++;
          if (cp0_epc === e.rd) n_pass++;
          else $display("FAIL %s cp0_epc: got %h expected %h", e.name, cp0_epc, e.rd);
        end
      end
      n_chk++;
      if (has_int === e.hint) n_pass++;
      else $display("FAIL %s has_int: got %b expected %b", e.name, has_int, e.hint);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0_we   = 1'b1;
    cp0_addr  = a;
    cp0_wdata = d;
    cyc();
    mtc0_we   = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [4:0] a, input logic [31:0] rd,
                     input logic hint);
    exp_t e;
    cp0_addr = a;
    e.name = nm; e.addr = a; e.chk_rd = 1'b1; e.rd = rd; e.hint = hint;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_int(input string nm, input logic hint);
    exp_t e;
    e.name = nm; e.addr = cp0_addr; e.chk_rd = 1'b0; e.rd = '0; e.hint = hint;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state, held in reset
    chk("rst_status", 5'd12, 32'h0040_0000, 1'b0);
    chk("rst_cause", 5'd13, 32'h0, 1'b0);
    chk("rst_epc", 5'd14, 32'h0, 1'b0);
    chk("rst_count", 5'd9, 32'h0, 1'b0);
    chk("rst_badvaddr", 5'd8, 32'h0, 1'b0);
    reset = 1'b0;
    // Park Compare far away so no timer match disturbs the early tests
    wr(5'd11, 32'hFFFF_0000);
    chk("compare_rd", 5'd11, TimerEn ? 32'hFFFF_0000 : 32'h0, 1'b0);

    // Status write mask
    wr(5'd12, 32'hFFFF_FFFF);
    chk("status_mask", 5'd12, 32'h0040_FF03, 1'b0);
    wr(5'd12, 32'h0);
    wr(5'd10, 32'hDEAD_BEEF);
    chk("unmapped", 5'd10, 32'h0, 1'b0);

    // Exception in delay slot with AdEL
    ws_ex = 1'b1; ws_bd = 1'b1; ws_pc = 32'hBFC0_0104; ws_excode = 5'h04;
    ws_badvaddr = 32'h0000_0003;
    cyc();
    ws_ex = 1'b0;
    chk("ex1_epc", 5'd14, 32'hBFC0_0100, 1'b0);
    chk("ex1_cause", 5'd13, 32'h8000_0010, 1'b0);
    chk("ex1_badva", 5'd8, 32'h0000_0003, 1'b0);
    chk("ex1_status", 5'd12, 32'h0040_0002, 1'b0);
    // Nested exception keeps EPC/BD
    ws_ex = 1'b1; ws_bd = 1'b0; ws_pc = 32'h8000_0000; ws_excode = 5'h08;
    ws_badvaddr = 32'h1234_5678;
    cyc();
    ws_ex = 1'b0;
    chk("ex2_epc", 5'd14, 32'hBFC0_0100, 1'b0);
    chk("ex2_cause", 5'd13, 32'h8000_0020, 1'b0);
    chk("ex2_badva", 5'd8, 32'h0000_0003, 1'b0);
    eret_flush = 1'b1;
    cyc();
    eret_flush = 1'b0;
    chk("eret_status", 5'd12, 32'h0040_0000, 1'b0);

    // Priority: ex beats eret beats mtc0
    wr(5'd12, 32'h0000_A501);
    chk("status_a5", 5'd12, 32'h0040_A501, 1'b0);
    ws_ex = 1'b1; ws_pc = 32'h8000_1000; ws_excode = 5'h0A;
    eret_flush = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
    cyc();
    ws_ex = 1'b0; mtc0_we = 1'b0;
    chk("prio_status", 5'd12, 32'h0040_A503, 1'b0);
    chk("prio_epc", 5'd14, 32'h8000_1000, 1'b0);
    chk("prio_cause", 5'd13, 32'h0000_0028, 1'b0);
    chk("prio_badva", 5'd8, 32'h0000_0003, 1'b0);
    mtc0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0;
    cyc();
    eret_flush = 1'b0; mtc0_we = 1'b0;
    chk("eret_over_mtc0", 5'd12, 32'h0040_A501, 1'b0);

    // Software interrupt bits and Cause write mask
    wr(5'd13, 32'h0000_0300);
    chk("sw_int", 5'd13, 32'h0000_0328, 1'b1);
    wr(5'd13, 32'hFFFF_FFFF);
    chk("cause_mask", 5'd13, 32'h0000_0328, 1'b1);
    wr(5'd13, 32'h0);
    chk("sw_int_clr", 5'd13, 32'h0000_0028, 1'b0);
    wr(5'd14, 32'h1234_5678);
    chk("epc_wr", 5'd14, 32'h1234_5678, 1'b0);

    // External interrupt: one cycle of latency on both edges
    cyc();
    ext_int = 6'b000001;
    chk_int("ext_pre", 1'b0);
    chk("ext_on", 5'd13, 32'h0000_0428, 1'b1);
    cyc();
    ext_int = 6'b000000;
    chk_int("ext_hold", 1'b1);
    chk_int("ext_off", 1'b0);

    // Asynchronous reset with no clock edge in between
    cyc();
    reset = 1'b1;
    chk("async_status", 5'd12, 32'h0040_0000, 1'b0);
    chk("async_epc", 5'd14, 32'h0, 1'b0);
    chk("async_cause", 5'd13, 32'h0, 1'b0);
    reset = 1'b0;

`ifdef CP0_TIMER_EN
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h0000_8001);
    chk("cnt_1", 5'd9, 32'd1, 1'b0);
    repeat (8) cyc();
    chk("cnt_5", 5'd9, 32'd5, 1'b0);
    chk("ti_set", 5'd13, 32'h4000_8000, 1'b1);
    chk("cnt_6", 5'd9, 32'd6, 1'b1);
    wr(5'd11, 32'd5);
    chk("ti_clr", 5'd13, 32'h0, 1'b0);
    wr(5'd9, 32'hFFFF_FFFF);
    chk("cnt_ld", 5'd9, 32'hFFFF_FFFF, 1'b0);
    chk("cnt_hold", 5'd9, 32'hFFFF_FFFF, 1'b0);
    chk("cnt_wrap", 5'd9, 32'h0, 1'b0);
`else
    wr(5'd9, 32'h55);
    chk("no_count", 5'd9, 32'h0, 1'b0);
    wr(5'd11, 32'h55);
    chk("no_compare", 5'd11, 32'h0, 1'b0);
    wr(5'd12, 32'h0000_8001);
    cyc();
    ext_int = 6'b100000;
    chk_int("ext5_pre", 1'b0);
    chk("ext5_on", 5'd13, 32'h0000_8000, 1'b1);
    ext_int = 6'b000000;
`endif

    // Drain the scoreboard within a bounded number of edges
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
